spi_frame_slave: RTL and testbench
==================================

# spi_frame_slave

SPI-mode-0 slave front end that feeds the command decoder on the 48 MHz HFOSC clock. It oversamples SCK, SS and MOSI, assembles each 32-bit frame into a holding register offered through an available/ack handshake, and returns one 24-bit response word per frame behind a status byte. It sits between the board SPI pins and the opcode/data consumer and drives the same `wr_*` / `rd_*` handshake that consumer already uses.

## Interface
- SYNC_STAGES, 2, flip-flops per input synchronizer (≥2).
- clk  in  1  system clock (SB_HFOSC, 48 MHz); SCK must be ≤ clk/8.
- reset_n  in  1  asynchronous, active-low reset.
- SPI_SCK  in  1  SPI clock, idle low, mode 0.
- SPI_SS  in  1  chip select, active low.
- SPI_MOSI  in  1  master data.
- SPI_MISO  out  1  slave data.
- rd_data  out  32  last complete received frame; [7:0] = first byte on the wire.
- rd_data_available  out  1  level; high while rd_data holds an unacknowledged frame.
- rd_ack  in  1  one-cycle pulse; consumes rd_data.
- wr_data  in  24  response payload.
- wr_en  in  1  one-cycle pulse; loads wr_data into the tx buffer.
- wr_buffer_free  out  1  high when the tx buffer is empty.
- overrun  out  1  sticky: a completed frame was dropped because rd_data was still held.

## Operation
- Reset values: SPI_MISO=0, rd_data=0, rd_data_available=0, wr_buffer_free=1, overrun=0; bit counter 0; tx buffer empty; shift registers 0.
- Bit order: MSB-first within each byte; bytes LSB-first. Byte 0 → rd_data[7:0], byte 3 → rd_data[31:24].
- Frame start (synchronized SS falling edge): clear bit counter and rx shift. Build tx shift = {payload, status}: status[0]=tx buffer full, status[1]=overrun, status[7:2]=0; payload = tx buffer if full, else 0. If the buffer is full, mark it in-flight. Drive the first MISO bit on the same cycle.
- Synchronized SCK rising: sample MOSI and increment the bit counter. Synchronized SCK falling: advance MISO to the next bit.
- 32nd rising edge (frame complete):
  - If rd_data_available=0: load rd_data and set available.
  - Otherwise: drop the frame and set overrun.
  - If the tx buffer is in-flight: clear it, so wr_buffer_free goes to 1.
  - If this frame's status carried overrun=1: clear overrun, unless this same frame overran.
- SS rising before 32 bits (abort): discard the partial rx. The tx buffer stays full and is resent in the next frame. overrun is unchanged.
- Rising edges after the 32nd bit in the same SS window are ignored. MISO=0 once the counter reaches 32.
- While SS is high: MISO=0 and SCK edges are ignored.
- wr_en while wr_buffer_free=0: ignored, buffer unchanged.
- wr_en on the same cycle as a frame-start detection: the word is stored but not sent until the next frame.
- rd_ack while rd_data_available=0: ignored.
- rd_ack on the same cycle as frame complete: the ack wins first, and the new frame loads (no overrun).

## Timing
- Input path: SYNC_STAGES flops, then one edge-detect flop. An SCK edge is acted on SYNC_STAGES+1 clk after it reaches the pin.
- rd_data_available rises 1 clk after the internal 32nd sample. rd_data_available falls 1 clk after rd_ack.
- wr_buffer_free falls 1 clk after wr_en. wr_buffer_free rises 1 clk after a completed frame that carried the word.
- MISO changes SYNC_STAGES+2 clk after an SCK falling edge. This stays inside the half-period at SCK ≤ clk/8.
- reset_n assertion mid-frame returns all state to reset values immediately. The first frame after release starts only on a fresh SS falling edge.

## Structure
- Package spi_frame_pkg holds:
  - FRAME_BITS=32, TX_BITS=24, STATUS_BITS=8.
  - STATUS_TXVALID=0, STATUS_OVERRUN=1.
- Sub-module spi_sync_edge (SYNC_STAGES synchronizer plus rise/fall pulse outputs): one instance each for SPI_SCK and SPI_SS. MOSI uses the synchronizer only, with no edge detect.

## Test plan
- Send bytes 0x04,0x00,0x00,0x05 → rd_data=0x05000004, available=1. Ack → available=0 one clk later.
- wr_en with 0x123456, then one frame → MISO bytes 0x01,0x56,0x34,0x12; wr_buffer_free 0→1 at frame end. Next frame → 0x00,0x00,0x00,0x00.
- Two frames without ack → second frame dropped, rd_data keeps the first, overrun=1. Next frame's status byte=0x02; overrun clears after that frame.
- Load 0xABCDEF, raise SS after 12 bits → no rd_data update, wr_buffer_free stays 0. Full frame after that → payload 0xABCDEF sent, buffer freed.
- reset_n low mid-frame after 20 bits, then a full frame 0x07 0 0 0 → rd_data=0x00000007, no overrun. wr_en while buffer is full → original word retained.

Source files
------------

// File: rtl/spi_frame_slave_pkg.sv
// spi_frame_slave: shared frame constants, FSM states and byte-order helper.
// Bytes travel LSB-first on the wire, bits MSB-first within each byte.
package spi_frame_pkg;

  localparam int FRAME_BITS     = 32;
  localparam int TX_BITS        = 24;
  localparam int STATUS_BITS    = 8;
  localparam int STATUS_TXVALID = 0;
  localparam int STATUS_OVERRUN = 1;
  localparam int CNT_W          = $clog2(FRAME_BITS) + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SHIFT,
    ST_DONE
  } frame_state_t;

  // Wire order <-> word order is a plain byte reversal.
  function automatic logic [FRAME_BITS-1:0] bswap(
    input logic [FRAME_BITS-1:0] w
  );
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spi_frame_slave_if.sv
// spi_frame_slave: consumer-side rd/wr handshake bundle.
// The slave modport is the SPI front end, master is the opcode consumer.
interface spi_frame_if;
  import spi_frame_pkg::*;

  logic [FRAME_BITS-1:0] rd_data;
  logic                  rd_data_available;
  logic                  rd_ack;
  logic [TX_BITS-1:0]    wr_data;
  logic                  wr_en;
  logic                  wr_buffer_free;
  logic                  overrun;

  modport slave (
    output rd_data,
    output rd_data_available,
    output wr_buffer_free,
    output overrun,
    input  rd_ack,
    input  wr_data,
    input  wr_en
  );

  modport master (
    input  rd_data,
    input  rd_data_available,
    input  wr_buffer_free,
    input  overrun,
    output rd_ack,
    output wr_data,
    output wr_en
  );

endinterface

// File: rtl/spi_frame_slave_sync_edge.sv
// spi_sync_edge: multi-flop synchronizer with registered edge detect.
// Reset to 0 so a pin held low through reset never produces a fall.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync;
  logic              prev;
  logic              level;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], pin};
      prev <= level;
    end
  end

  assign level = sync[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/spi_frame_slave.sv
// spi_frame_slave: SPI mode-0 slave, 32-bit rx frames in, status+24-bit
// response out, oversampled on the system clock.
module spi_frame_slave
  import spi_frame_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        SPI_SCK,
  input  logic        SPI_SS,
  input  logic        SPI_MOSI,
  output logic        SPI_MISO,
  spi_frame_if.slave  host
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_BITS - 1);

  logic sck_rise, sck_fall;
  logic ss_rise, ss_fall;
  logic [SYNC_STAGES-1:0] mosi_sync;
  logic mosi_s;

  frame_state_t state, state_next;
  logic frame_start, sample, advance;
  logic frame_done, abort;

  logic [CNT_W-1:0]      bit_cnt;
  logic [FRAME_BITS-2:0] rx_shift;
  logic [FRAME_BITS-1:0] tx_shift;
  logic [FRAME_BITS-1:0] rx_word;
  logic [FRAME_BITS-1:0] tx_word;
  logic [STATUS_BITS-1:0] status;
  logic                  sent_ovr;
  logic                  miso;

  logic [FRAME_BITS-1:0] rd_data;
  logic                  avail;
  logic                  overrun;
  logic [TX_BITS-1:0]    tx_buf;
  logic                  tx_full;
  logic                  tx_inflight;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (SPI_SCK),
    .rise    (sck_rise),
    .fall    (sck_fall)
  );

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_ss (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (SPI_SS),
    .rise    (ss_rise),
    .fall    (ss_fall)
  );

  // MOSI shares the synchronizer depth so it lines up with sck_rise.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) mosi_sync <= '0;
    else          mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], SPI_MOSI};
  end

  assign mosi_s = mosi_sync[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_next;
  end

  always_comb begin
    state_next  = state;
    frame_start = 1'b0;
    sample      = 1'b0;
    advance     = 1'b0;
    frame_done  = 1'b0;
    abort       = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (ss_fall) begin
          frame_start = 1'b1;
          state_next  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (ss_rise) begin
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else if (sck_rise) begin
          sample = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            frame_done = 1'b1;
            state_next = ST_DONE;
          end
        end else if (sck_fall) begin
          advance = 1'b1;
        end
      end
      ST_DONE: begin
        if (ss_rise) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    status                 = '0;
    status[STATUS_TXVALID] = tx_full;
    status[STATUS_OVERRUN] = overrun;
  end

  assign tx_word = bswap({tx_full ? tx_buf : '0, status});
  assign rx_word = {rx_shift, mosi_s};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= '0;
      sent_ovr <= 1'b0;
      miso     <= 1'b0;
    end else if (frame_start) begin
      bit_cnt  <= '0;
      rx_shift <= '0;
      tx_shift <= tx_word;
      sent_ovr <= overrun;
      miso     <= tx_word[FRAME_BITS-1];
    end else begin
      // MISO trails the shift register by one clk.
      miso <= (state_next == ST_SHIFT) ? tx_shift[FRAME_BITS-1] : 1'b0;
      if (sample) begin
        rx_shift <= rx_word[FRAME_BITS-2:0];
        bit_cnt  <= bit_cnt + 1'b1;
      end
      if (advance) tx_shift <= {tx_shift[FRAME_BITS-2:0], 1'b0};
      if (abort)   rx_shift <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_data     <= '0;
      avail       <= 1'b0;
      overrun     <= 1'b0;
      tx_buf      <= '0;
      tx_full     <= 1'b0;
      tx_inflight <= 1'b0;
    end else begin
      if (frame_done && (!avail || host.rd_ack)) begin
        rd_data <= bswap(rx_word);
        avail   <= 1'b1;
      end else if (host.rd_ack) begin
        avail <= 1'b0;
      end
      if (frame_done && avail && !host.rd_ack) overrun <= 1'b1;
      else if (frame_done && sent_ovr)         overrun <= 1'b0;
      if (host.wr_en && !tx_full) begin
        tx_buf  <= host.wr_data;
        tx_full <= 1'b1;
      end
      if (frame_start && tx_full) begin
        tx_inflight <= 1'b1;
      end else if (frame_done && tx_inflight) begin
        tx_full     <= 1'b0;
        tx_inflight <= 1'b0;
      end else if (abort) begin
        tx_inflight <= 1'b0;
      end
    end
  end

  assign SPI_MISO               = miso;
  assign host.rd_data           = rd_data;
  assign host.rd_data_available = avail;
  assign host.overrun           = overrun;
  assign host.wr_buffer_free    = ~tx_full;

endmodule

// File: tb/tb_spi_frame_slave.sv
// tb_spi_frame_slave: vector table, corner sequences and a random
// phase checked against a frame-level model of the slave.
module tb_spi_frame_slave;
  import spi_frame_pkg::*;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic sck = 1'b0;
  logic ss = 1'b1;
  logic mosi = 1'b0;
  logic miso;

  spi_frame_if host_if ();

  spi_frame_slave #(.SYNC_STAGES(2)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .SPI_SCK  (sck),
    .SPI_SS   (ss),
    .SPI_MOSI (mosi),
    .SPI_MISO (miso),
    .host     (host_if)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int passed = 0;

  typedef struct {
    bit          wr;
    logic [23:0] wd;
    bit          ack;
    int          nbits;
    logic [31:0] mosi_w;
    logic [31:0] miso_w;
    logic [31:0] rd;
    bit          avail;
    bit          ovr;
    bit          free;
  } vec_t;

  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp)
      $display("FAIL %s: got %h want %h", name, act, exp);
    else
      passed++;
  endtask

  function automatic int widx(input int k);
    return 8 * (k / 8) + 7 - (k % 8);
  endfunction

  task automatic send_bits(input logic [31:0] tx, input int nbits,
                           input bit ack_last, output logic [31:0] rx);
    rx = '0;
    for (int k = 0; k < nbits; k++) begin
      mosi = tx[widx(k)];
      repeat (8) @(negedge clk);
      rx[widx(k)] = miso;
      sck = 1'b1;
      if (ack_last && k == nbits - 1) begin
        repeat (2) @(negedge clk);
        host_if.rd_ack = 1'b1;
        @(negedge clk);
        host_if.rd_ack = 1'b0;
        repeat (5) @(negedge clk);
      end else begin
        repeat (8) @(negedge clk);
      end
      sck = 1'b0;
    end
    mosi = 1'b0;
  endtask

  task automatic frame(input logic [31:0] tx, input int nbits,
                       input bit ack_last, output logic [31:0] rx);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(tx, nbits, ack_last, rx);
    repeat (8) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic pulse_wr(input logic [23:0] d);
    host_if.wr_data = d;
    host_if.wr_en = 1'b1;
    @(negedge clk);
    host_if.wr_en = 1'b0;
  endtask

  task automatic pulse_ack();
    host_if.rd_ack = 1'b1;
    @(negedge clk);
    host_if.rd_ack = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_miso"}, 32'(miso), 32'h0);
    chk({tag, "_rd"}, host_if.rd_data, 32'h0);
    chk({tag, "_avail"}, 32'(host_if.rd_data_available), 32'h0);
    chk({tag, "_free"}, 32'(host_if.wr_buffer_free), 32'h1);
    chk({tag, "_ovr"}, 32'(host_if.overrun), 32'h0);
  endtask

  logic [31:0] rx;
  bit          m_avail, m_ovr, m_full, dropped;
  logic [31:0] m_data, exp_word, mask, tx;
  logic [23:0] m_buf, wd;
  int          nbits;
  bit          do_wr, do_ack, ack_last;

  initial begin
    host_if.rd_ack = 1'b0;
    host_if.wr_en = 1'b0;
    host_if.wr_data = '0;

    vecs[0] = '{1'b1, 24'h123456, 1'b0, 32, 32'h11111111, 32'h12345601,
                32'h11111111, 1'b1, 1'b0, 1'b1};
    vecs[1] = '{1'b0, 24'h0, 1'b1, 32, 32'h22222222, 32'h00000000,
                32'h22222222, 1'b1, 1'b0, 1'b1};
    vecs[2] = '{1'b0, 24'h0, 1'b0, 32, 32'h33333333, 32'h00000000,
                32'h22222222, 1'b1, 1'b1, 1'b1};
    vecs[3] = '{1'b0, 24'h0, 1'b1, 32, 32'h44444444, 32'h00000002,
                32'h44444444, 1'b1, 1'b0, 1'b1};
    vecs[4] = '{1'b1, 24'hABCDEF, 1'b1, 12, 32'h55555555, 32'h0000E001,
                32'h44444444, 1'b0, 1'b0, 1'b0};
    vecs[5] = '{1'b0, 24'h0, 1'b0, 32, 32'h66666666, 32'hABCDEF01,
                32'h66666666, 1'b1, 1'b0, 1'b1};
    vecs[6] = '{1'b0, 24'h0, 1'b1, 32, 32'h77777777, 32'h00000000,
                32'h77777777, 1'b1, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    chk_reset_state("rst");
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    frame(32'h05000004, 32, 1'b0, rx);
    chk("first_rd", host_if.rd_data, 32'h05000004);
    chk("first_avail", 32'(host_if.rd_data_available), 32'h1);
    chk("first_miso", rx, 32'h0);
    pulse_ack();
    chk("ack_avail", 32'(host_if.rd_data_available), 32'h0);

    for (int i = 0; i < 7; i++) begin
      if (vecs[i].wr) begin
        pulse_wr(vecs[i].wd);
        chk($sformatf("v%0d_free_wr", i), 32'(host_if.wr_buffer_free), 32'h0);
      end
      if (vecs[i].ack) pulse_ack();
      frame(vecs[i].mosi_w, vecs[i].nbits, 1'b0, rx);
      chk($sformatf("v%0d_miso", i), rx, vecs[i].miso_w);
      chk($sformatf("v%0d_rd", i), host_if.rd_data, vecs[i].rd);
      chk($sformatf("v%0d_avail", i), 32'(host_if.rd_data_available),
          32'(vecs[i].avail));
      chk($sformatf("v%0d_ovr", i), 32'(host_if.overrun), 32'(vecs[i].ovr));
      chk($sformatf("v%0d_free", i), 32'(host_if.wr_buffer_free),
          32'(vecs[i].free));
    end

    // Reset in the middle of a frame, then a frame on a fresh SS fall.
    pulse_wr(24'h5A5A5A);
    ss = 1'b0;
    repeat (8) @(negedge clk);
    send_bits(32'hFFFFFFFF, 20, 1'b0, rx);
    reset_n = 1'b0;
    #1;
    chk_reset_state("midrst");
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    send_bits(32'hFFFFFFFF, 4, 1'b0, rx);
    repeat (8) @(negedge clk);
    ss = 1'b1;
    repeat (8) @(negedge clk);
    chk("postrst_avail", 32'(host_if.rd_data_available), 32'h0);
    chk("postrst_rd", host_if.rd_data, 32'h0);
    frame(32'h00000007, 32, 1'b0, rx);
    chk("postrst_frame_rd", host_if.rd_data, 32'h00000007);
    chk("postrst_frame_avail", 32'(host_if.rd_data_available), 32'h1);
    chk("postrst_frame_ovr", 32'(host_if.overrun), 32'h0);
    chk("postrst_frame_miso", rx, 32'h0);

    pulse_wr(24'h111111);
    chk("wr_full_free", 32'(host_if.wr_buffer_free), 32'h0);
    pulse_wr(24'h222222);
    pulse_ack();
    frame(32'h0, 32, 1'b0, rx);
    chk("wr_full_kept", rx, 32'h11111101);
    chk("wr_full_freed", 32'(host_if.wr_buffer_free), 32'h1);

    // Random frames against a frame-level model.
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);
    m_avail = 0; m_ovr = 0; m_full = 0;
    m_data = '0; m_buf = '0;
    for (int i = 0; i < 40; i++) begin
      do_wr  = bit'($urandom_range(0, 1));
      do_ack = bit'($urandom_range(0, 1));
      wd     = 24'($urandom);
      tx     = $urandom;
      nbits  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 31)) : 32;
      ack_last = (nbits == 32) && ($urandom_range(0, 3) == 0);
      if (do_wr) begin
        pulse_wr(wd);
        if (!m_full) begin
          m_full = 1;
          m_buf = wd;
        end
      end
      if (do_ack) begin
        pulse_ack();
        m_avail = 0;
      end
      exp_word = {m_full ? m_buf : 24'h0, 6'b0, m_ovr, m_full};
      mask = '0;
      for (int k = 0; k < nbits; k++) mask[widx(k)] = 1'b1;
      frame(tx, nbits, ack_last, rx);
      chk($sformatf("r%0d_miso", i), rx, exp_word & mask);
      if (nbits == 32) begin
        if (ack_last) m_avail = 0;
        dropped = m_avail;
        if (!dropped) begin
          m_data = tx;
          m_avail = 1;
        end else begin
          m_ovr = 1;
        end
        m_full = 0;
        if (exp_word[1] && !dropped) m_ovr = 0;
      end
      chk($sformatf("r%0d_rd", i), host_if.rd_data, m_data);
      chk($sformatf("r%0d_avail", i), 32'(host_if.rd_data_available),
          32'(m_avail));
      chk($sformatf("r%0d_ovr", i), 32'(host_if.overrun), 32'(m_ovr));
      chk($sformatf("r%0d_free", i), 32'(host_if.wr_buffer_free),
          32'(!m_full));
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
